// File: rtl/fpga_rst_pkg.sv
// Shared types for the FPGA reset sequencer: FSM states and reset-cause codes.
package fpga_rst_pkg;

  localparam int CAUSE_W = 2;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } rst_state_e;

  typedef enum logic [CAUSE_W-1:0] {
    RST_POR  = 2'd0,
    RST_LOCK = 2'd1,
    RST_SW   = 2'd2
  } rst_cause_e;

endpackage

// File: rtl/rst_sync_2ff.sv
// Two-flop synchroniser for a level signal; both stages clear to 0 on async reset.
module rst_sync_2ff (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/fpga_rst_seq.sv
// Reset sequencer: holds SoC reset domains until PLL lock, then releases them staggered.
// Optional lock stability filter in WAIT_LOCK enabled by `define RST_SEQ_LOCK_FILT_EN.
module fpga_rst_seq
  import fpga_rst_pkg::*;
#(
  parameter int NUM_DOM     = 3,
  parameter int HOLD_CYC    = 16,
  parameter int STAGGER_CYC = 8,
  parameter int CNT_W       = 16,
  parameter int FILT_CYC    = 1024
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               pll_lock_i,
  input  logic               sw_rst_req_i,
  output logic [NUM_DOM-1:0] dom_rst_n_o,
  output logic               rdy_o,
  output logic [CAUSE_W-1:0] rst_cause_o
);

  localparam int MAX_HS  = (HOLD_CYC > STAGGER_CYC) ? HOLD_CYC : STAGGER_CYC;
  localparam int MAX_CYC = (MAX_HS > FILT_CYC) ? MAX_HS : FILT_CYC;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_CYC - 1);
`ifdef RST_SEQ_LOCK_FILT_EN
  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILT_CYC - 1);
`endif

  rst_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_DOM-1:0] dom_q, dom_d;
  rst_cause_e         cause_q, cause_d;
  logic               lock_s;

  // Saturate rather than wrap so a stuck count can never alias a terminal value.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  rst_sync_2ff u_lock_sync (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .d_i    (pll_lock_i),
    .q_o    (lock_s)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      dom_q   <= '0;
      cause_q <= RST_POR;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dom_q   <= dom_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dom_d   = dom_q;
    cause_d = cause_q;
    case (state_q)
      WAIT_LOCK: begin
        dom_d = '0;
`ifdef RST_SEQ_LOCK_FILT_EN
        if (!lock_s) begin
          cnt_d = '0;
        end else if (cnt_q == FILT_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc(cnt_q);
        end
`else
        if (lock_s) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
`endif
      end
      default: begin
        // Lock loss outranks a software request arriving in the same cycle.
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          dom_d   = '0;
          cause_d = RST_LOCK;
        end else if (sw_rst_req_i) begin
          state_d = HOLD;
          cnt_d   = '0;
          dom_d   = '0;
          cause_d = RST_SW;
        end else begin
          case (state_q)
            HOLD: begin
              if (cnt_q == HOLD_LAST) begin
                state_d = RELEASE;
                dom_d   = NUM_DOM'(1);
                cnt_d   = '0;
              end else begin
                cnt_d = cnt_inc(cnt_q);
              end
            end
            RELEASE: begin
              if (dom_q[NUM_DOM-1]) begin
                state_d = RUN;
              end else if (cnt_q == STAG_LAST) begin
                dom_d = (dom_q << 1) | NUM_DOM'(1);
                cnt_d = '0;
              end else begin
                cnt_d = cnt_inc(cnt_q);
              end
            end
            default: dom_d = '1;
          endcase
        end
      end
    endcase
  end

  assign dom_rst_n_o = dom_q;
  assign rdy_o       = (state_q == RUN);
  assign rst_cause_o = cause_q;

endmodule

// File: tb/tb_fpga_rst_seq.sv
// Scoreboard bench for fpga_rst_seq: time-offset reference model feeds an expectation queue.
module tb_fpga_rst_seq;

  localparam int NUM_DOM     = 3;
  localparam int HOLD_CYC    = 16;
  localparam int STAGGER_CYC = 8;
  localparam int CNT_W       = 16;
  localparam int FILT_CYC    = 100;

  typedef struct packed {
    logic [NUM_DOM-1:0] dom;
    logic               rdy;
    logic [1:0]         cause;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               pll = 1'b0;
  logic               sw = 1'b0;
  logic [NUM_DOM-1:0] dom;
  logic               rdy;
  logic [1:0]         cause;

  exp_t exp_q[$];
  exp_t mon_e;
  exp_t mon_a;
  int   tests = 0;
  int   fails = 0;

  // Reference model: sequence described by its start edge and elapsed edges.
  bit m_seq;
  int m_t0;
  int m_cause;
  int m_run;
  int edge_k;
  bit p1, p2;

  fpga_rst_seq #(
    .NUM_DOM    (NUM_DOM),
    .HOLD_CYC   (HOLD_CYC),
    .STAGGER_CYC(STAGGER_CYC),
    .CNT_W      (CNT_W),
    .FILT_CYC   (FILT_CYC)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .pll_lock_i  (pll),
    .sw_rst_req_i(sw),
    .dom_rst_n_o (dom),
    .rdy_o       (rdy),
    .rst_cause_o (cause)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_seq = 0; m_t0 = 0; m_cause = 0; m_run = 0; edge_k = 0; p1 = 0; p2 = 0;
  endtask

  function automatic exp_t model_step(input bit p, input bit s);
    exp_t r;
    bit   l;
    int   e;
    edge_k++;
    l  = p2;
    p2 = p1;
    p1 = p;
    if (!m_seq) begin
`ifdef RST_SEQ_LOCK_FILT_EN
      m_run = l ? m_run + 1 : 0;
      if (m_run >= FILT_CYC) begin m_seq = 1; m_t0 = edge_k; end
`else
      if (l) begin m_seq = 1; m_t0 = edge_k; end
`endif
    end else if (!l) begin
      m_seq = 0; m_cause = 1; m_run = 0;
    end else if (s) begin
      m_t0 = edge_k; m_cause = 2;
    end
    e = edge_k - m_t0;
    for (int i = 0; i < NUM_DOM; i++)
      r.dom[i] = m_seq && (e >= HOLD_CYC + i * STAGGER_CYC);
    r.rdy   = m_seq && (e >= HOLD_CYC + (NUM_DOM - 1) * STAGGER_CYC + 1);
    r.cause = 2'(m_cause);
    return r;
  endfunction

  task automatic drive(input bit p, input bit s);
    pll = p;
    sw  = s;
    exp_q.push_back(model_step(p, s));
  endtask

  task automatic step(input bit p, input bit s);
    @(negedge clk);
    #1;
    drive(p, s);
  endtask

  task automatic run(input int n, input bit p);
    for (int i = 0; i < n; i++) step(p, 1'b0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = {dom, rdy, cause};
      tests++;
      if (mon_a !== mon_e) begin
        fails++;
        $display("FAIL outputs @%0t: dom=%b rdy=%b cause=%0d, expected dom=%b rdy=%b cause=%0d",
                 $time, mon_a.dom, mon_a.rdy, mon_a.cause, mon_e.dom, mon_e.rdy, mon_e.cause);
      end
    end
  end

  initial begin
    model_reset();
    pll = 1'b1;
    #23;
    chk("reset_dom", 32'(dom), 32'd0);
    chk("reset_rdy", 32'(rdy), 32'd0);
    chk("reset_cause", 32'(cause), 32'd0);

    // Power-on sequence with lock present from the start.
    @(negedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    drive(1'b1, 1'b0);
    run(45 + FILT_CYC, 1'b1);

    // Lock loss in RUN, then recovery.
    run(5, 1'b0);
    run(45 + FILT_CYC, 1'b1);

    // Software request in RUN.
    step(1'b1, 1'b1);
    run(45, 1'b1);

    // Software request in RELEASE after dom0 is out.
    step(1'b1, 1'b1);
    run(20, 1'b1);
    step(1'b1, 1'b1);
    run(45, 1'b1);

    // Lock loss seen on the same edge as a software request.
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    run(45 + FILT_CYC, 1'b1);

    // Software request then async reset mid-RELEASE.
    step(1'b1, 1'b1);
    run(22, 1'b1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("async_rst_dom", 32'(dom), 32'd0);
    chk("async_rst_rdy", 32'(rdy), 32'd0);
    chk("async_rst_cause", 32'(cause), 32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    drive(1'b1, 1'b0);
    run(45 + FILT_CYC, 1'b1);

    for (int r = 0; r < 40; r++) begin
      case ($urandom_range(0, 4))
        0: run($urandom_range(5, 60), 1'b1);
        1: run($urandom_range(1, 6), 1'b0);
        2: step(1'b1, 1'b1);
        3: begin
          step(1'b0, 1'b0);
          step(1'b1, 1'b0);
          step(1'b1, 1'b1);
        end
        default: begin
          for (int i = 0; i < 30; i++) step($urandom_range(0, 15) != 0, $urandom_range(0, 20) == 0);
        end
      endcase
    end
    run(45 + FILT_CYC, 1'b1);

    @(negedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
